// File: rtl/secded_dec72_if.sv
// secded_dec72_if: datapath bundle for the 72->64 SECDED decoder.
//   in_valid / in_data   : incoming codeword (data [63:0], check bits [71:64])
//   out_valid / out_data : corrected 64-bit word
//   out_syn              : syndrome of the word on out_data
//   out_ce / out_ue      : corrected / uncorrectable flags
// modport master: the codeword source (and consumer of the results).
// modport slave : the decoder.
interface secded_dec72_if;
    logic        in_valid;
    logic [71:0] in_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_syn;
    logic        out_ce;
    logic        out_ue;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_syn, out_ce, out_ue
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_syn, out_ce, out_ue
    );
endinterface

// File: rtl/secded_dec72.sv
// secded_dec72: two-stage pipelined 72->64 SECDED decoder with saturating
// error counters.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : secded_dec72_if.slave (codeword in, corrected word out)
//   cnt_clr    : synchronous clear of both counters (and of the error log)
//   ce_cnt     : saturating count of corrected errors
//   ue_cnt     : saturating count of uncorrectable errors
//   log_syn, log_vld : syndrome of the first error since the last clear
//                      (present only when SECDED_DEC_ERRLOG_EN is defined)
// Parity-check matrix (shared with the encoder): data column j is the j-th
// 8-bit value of odd weight, taking all 56 weight-3 values in ascending order
// followed by the 8 smallest weight-5 values. Check bit k has column 1<<k.
// Every data column has weight >= 3, so a data-bit hit can never be confused
// with a check-bit hit (weight 1) or with a double error (even weight).
module secded_dec72 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    secded_dec72_if.slave    bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ce_cnt,
    output logic [CNT_W-1:0] ue_cnt
`ifdef SECDED_DEC_ERRLOG_EN
    ,
    output logic [7:0]       log_syn,
    output logic             log_vld
`endif
);

    function automatic logic [63:0][7:0] build_h_cols();
        logic [63:0][7:0] cols;
        int n;
        int w;
        cols = '0;
        n    = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 1; v < 256; v++) begin
                w = 0;
                for (int b = 0; b < 8; b++) begin
                    w += (v >> b) & 1;
                end
                if ((w == ((pass == 0) ? 3 : 5)) && (n < 64)) begin
                    cols[n] = 8'(v);
                    n++;
                end
            end
        end
        return cols;
    endfunction

    localparam logic [63:0][7:0]  H_COLS  = build_h_cols();
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    // ---------------- stage 1: syndrome ----------------
    logic [7:0]  syn_next;
    logic        s1_valid_reg;
    logic [63:0] s1_data_reg;
    logic [7:0]  s1_syn_reg;

    always_comb begin
        syn_next = bus.in_data[71:64];
        for (int j = 0; j < 64; j++) begin
            if (bus.in_data[j]) begin
                syn_next = syn_next ^ H_COLS[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_syn_reg   <= '0;
        end else begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data_reg <= bus.in_data[63:0];
                s1_syn_reg  <= syn_next;
            end
        end
    end

    // ---------------- stage 2: correction ----------------
    logic [63:0] data_hit;
    logic        chk_hit;
    logic        ce_next;
    logic        ue_next;

    for (genvar gi = 0; gi < 64; gi++) begin : g_col
        assign data_hit[gi] = (s1_syn_reg == H_COLS[gi]);
    end

    assign chk_hit = $onehot(s1_syn_reg);
    assign ce_next = (|data_hit) | chk_hit;
    assign ue_next = (s1_syn_reg != 8'h00) & ~ce_next;

    logic        out_valid_reg;
    logic [63:0] out_data_reg;
    logic [7:0]  out_syn_reg;
    logic        out_ce_reg;
    logic        out_ue_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_syn_reg   <= '0;
            out_ce_reg    <= 1'b0;
            out_ue_reg    <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                // data_hit is all-zero unless the syndrome names a data bit
                out_data_reg <= s1_data_reg ^ data_hit;
                out_syn_reg  <= s1_syn_reg;
                out_ce_reg   <= ce_next;
                out_ue_reg   <= ue_next;
            end
        end
    end

    logic ce_evt;
    logic ue_evt;

    assign ce_evt = out_valid_reg & out_ce_reg;
    assign ue_evt = out_valid_reg & out_ue_reg;

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_syn   = out_syn_reg;
    assign bus.out_ce    = ce_evt;
    assign bus.out_ue    = ue_evt;

    // ---------------- counters ----------------
    logic [CNT_W-1:0] ce_cnt_reg;
    logic [CNT_W-1:0] ue_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_cnt_reg <= '0;
            ue_cnt_reg <= '0;
        end else if (cnt_clr) begin
            // clear wins; a coincident event is deliberately not counted
            ce_cnt_reg <= '0;
            ue_cnt_reg <= '0;
        end else begin
            if (ce_evt && (ce_cnt_reg != CNT_MAX)) begin
                ce_cnt_reg <= ce_cnt_reg + 1'b1;
            end
            if (ue_evt && (ue_cnt_reg != CNT_MAX)) begin
                ue_cnt_reg <= ue_cnt_reg + 1'b1;
            end
        end
    end

    assign ce_cnt = ce_cnt_reg;
    assign ue_cnt = ue_cnt_reg;

`ifdef SECDED_DEC_ERRLOG_EN
    // ---------------- first-error log ----------------
    logic [7:0] log_syn_reg;
    logic       log_vld_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_syn_reg <= '0;
            log_vld_reg <= 1'b0;
        end else if (cnt_clr) begin
            log_syn_reg <= '0;
            log_vld_reg <= 1'b0;
        end else if ((ce_evt || ue_evt) && !log_vld_reg) begin
            log_syn_reg <= out_syn_reg;
            log_vld_reg <= 1'b1;
        end
    end

    assign log_syn = log_syn_reg;
    assign log_vld = log_vld_reg;
`endif

endmodule

// File: tb/tb_secded_dec72.sv
module tb_secded_dec72;

    logic clk = 1'b0;
    logic rst_n;
    logic cnt_clr;

    always #5 clk = ~clk;

    secded_dec72_if bus16 ();
    secded_dec72_if bus4 ();

    logic [15:0] ce16, ue16;
    logic [3:0]  ce4, ue4;
`ifdef SECDED_DEC_ERRLOG_EN
    logic [7:0] lsyn16, lsyn4;
    logic       lvld16, lvld4;
`endif

    secded_dec72 #(.CNT_W(16)) dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus16),
        .cnt_clr (cnt_clr),
        .ce_cnt  (ce16),
        .ue_cnt  (ue16)
`ifdef SECDED_DEC_ERRLOG_EN
        ,
        .log_syn (lsyn16),
        .log_vld (lvld16)
`endif
    );

    secded_dec72 #(.CNT_W(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus4),
        .cnt_clr (cnt_clr),
        .ce_cnt  (ce4),
        .ue_cnt  (ue4)
`ifdef SECDED_DEC_ERRLOG_EN
        ,
        .log_syn (lsyn4),
        .log_vld (lvld4)
`endif
    );

    int checks = 0;
    int errors = 0;

    // reference H columns: odd-weight bytes, weight 3 ascending then weight 5
    logic [7:0] cols [64];

    // behavioural model state
    logic        p1_v;
    logic [71:0] p1_d;
    logic        ex_valid;
    logic [63:0] ex_data;
    logic [7:0]  ex_syn;
    logic        ex_ce, ex_ue;
    int          m_ce16, m_ue16, m_ce4, m_ue4;
    logic [7:0]  m_lsyn;
    logic        m_lvld;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_cols();
        int n = 0;
        for (int w = 3; w <= 5; w += 2) begin
            for (int v = 1; v < 256; v++) begin
                if ($countones(v) == w && n < 64) begin
                    cols[n] = 8'(v);
                    n++;
                end
            end
        end
    endtask

    function automatic logic [71:0] encode(input logic [63:0] d);
        logic [7:0] c = 8'h00;
        for (int j = 0; j < 64; j++) if (d[j]) c ^= cols[j];
        return {c, d};
    endfunction

    task automatic ref_decode(input logic [71:0] w, output logic [63:0] d,
                              output logic [7:0] s, output logic ce, output logic ue);
        int found = -1;
        s  = w[71:64];
        for (int j = 0; j < 64; j++) if (w[j]) s ^= cols[j];
        d  = w[63:0];
        ce = 1'b0;
        ue = 1'b0;
        if (s != 8'h00) begin
            for (int j = 0; j < 64; j++) if (cols[j] == s) found = j;
            if (found >= 0) begin
                d[found] = ~d[found];
                ce = 1'b1;
            end else if ($countones(s) == 1) begin
                ce = 1'b1;
            end else begin
                ue = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        p1_v = 0; p1_d = '0;
        ex_valid = 0; ex_data = '0; ex_syn = '0; ex_ce = 0; ex_ue = 0;
        m_ce16 = 0; m_ue16 = 0; m_ce4 = 0; m_ue4 = 0;
        m_lsyn = '0; m_lvld = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid16", 72'(bus16.out_valid), 72'(ex_valid));
        chk("out_data16",  72'(bus16.out_data),  72'(ex_data));
        chk("out_syn16",   72'(bus16.out_syn),   72'(ex_syn));
        chk("out_ce16",    72'(bus16.out_ce),    72'(ex_valid & ex_ce));
        chk("out_ue16",    72'(bus16.out_ue),    72'(ex_valid & ex_ue));
        chk("out_data4",   72'(bus4.out_data),   72'(ex_data));
        chk("out_ce4",     72'(bus4.out_ce),     72'(ex_valid & ex_ce));
        chk("ce_cnt16",    72'(ce16), 72'(m_ce16));
        chk("ue_cnt16",    72'(ue16), 72'(m_ue16));
        chk("ce_cnt4",     72'(ce4),  72'(m_ce4));
        chk("ue_cnt4",     72'(ue4),  72'(m_ue4));
`ifdef SECDED_DEC_ERRLOG_EN
        chk("log_vld",     72'(lvld16), 72'(m_lvld));
        chk("log_syn",     72'(lsyn16), 72'(m_lsyn));
`endif
    endtask

    // one clock: check what is visible, account for this cycle's counter
    // edge, then present the next input
    task automatic tick(input logic v, input logic [71:0] d, input logic clr);
        @(negedge clk);
        check_outputs();
        if (clr) begin
            m_ce16 = 0; m_ue16 = 0; m_ce4 = 0; m_ue4 = 0;
            m_lsyn = '0; m_lvld = 0;
        end else if (ex_valid) begin
            if (ex_ce) begin
                if (m_ce16 < 65535) m_ce16++;
                if (m_ce4 < 15) m_ce4++;
            end
            if (ex_ue) begin
                if (m_ue16 < 65535) m_ue16++;
                if (m_ue4 < 15) m_ue4++;
            end
            if ((ex_ce || ex_ue) && !m_lvld) begin
                m_lsyn = ex_syn;
                m_lvld = 1;
            end
        end
        bus16.in_valid = v; bus16.in_data = d;
        bus4.in_valid  = v; bus4.in_data  = d;
        cnt_clr = clr;
        ex_valid = p1_v;
        if (p1_v) ref_decode(p1_d, ex_data, ex_syn, ex_ce, ex_ue);
        p1_v = v;
        p1_d = d;
        $display("t=%0t in_valid=%0b in_data=%018h clr=%0b | out_valid=%0b out_data=%016h syn=%02h ce=%0b ue=%0b ce_cnt=%0d ue_cnt=%0d",
                 $time, v, d, clr, bus16.out_valid, bus16.out_data, bus16.out_syn,
                 bus16.out_ce, bus16.out_ue, ce16, ue16);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 72'h0, 1'b0);
    endtask

    initial begin
        logic [71:0] w;
        logic [71:0] one;
        int          prev_ce, prev_ue, kind, b1, b2;

        build_cols();
        model_reset();
        one = 72'h1;
        rst_n = 1'b0;
        cnt_clr = 1'b0;
        bus16.in_valid = 0; bus16.in_data = '0;
        bus4.in_valid  = 0; bus4.in_data  = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 72'(bus16.out_valid), 72'h0);
        chk("rst_ce_cnt",    72'(ce16), 72'h0);
        chk("rst_ue_cnt",    72'(ue16), 72'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // clean words
        tick(1'b1, 72'h0, 1'b0);
        tick(1'b1, encode(64'hDEADBEEF_01234567), 1'b0);
        idle(2);
        chk("clean_data", 72'(bus16.out_data), 72'h0000_DEADBEEF_01234567);
        chk("clean_syn",  72'(bus16.out_syn),  72'h0);
        idle(2);
        chk("clean_ce_cnt", 72'(ce16), 72'h0);

        // all 72 single flips of the zero codeword, back to back
        for (int i = 0; i < 72; i++) tick(1'b1, one << i, 1'b0);
        idle(4);
        chk("flip_ce_cnt72", 72'(ce16), 72'd72);
        chk("flip_ue_cnt0",  72'(ue16), 72'd0);
        chk("flip_ce4_sat",  72'(ce4),  72'd15);

        // double flip
        prev_ce = m_ce16; prev_ue = m_ue16;
        tick(1'b1, 72'h3, 1'b0);
        idle(2);
        chk("dbl_ue",   72'(bus16.out_ue),   72'h1);
        chk("dbl_data", 72'(bus16.out_data), 72'h3);
        idle(2);
        chk("dbl_ue_cnt", 72'(ue16), 72'(prev_ue + 1));
        chk("dbl_ce_cnt", 72'(ce16), 72'(prev_ce));

        // saturation of the 4-bit counter, then clear against a counted CE
        tick(1'b0, 72'h0, 1'b1);
        for (int i = 0; i < 17; i++) tick(1'b1, one << $urandom_range(0, 71), 1'b0);
        idle(4);
        chk("sat17", 72'(ce4), 72'd15);
        tick(1'b1, one << 9, 1'b0);
        idle(4);
        chk("sat18", 72'(ce4), 72'd15);
        tick(1'b1, one << 20, 1'b0);
        tick(1'b0, 72'h0, 1'b0);
        tick(1'b0, 72'h0, 1'b1);
        idle(3);
        chk("clr_wins4",  72'(ce4),  72'd0);
        chk("clr_wins16", 72'(ce16), 72'd0);

        // randomized mix
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            w = encode({$urandom, $urandom});
            b1 = $urandom_range(0, 71);
            b2 = (b1 + $urandom_range(1, 71)) % 72;
            if (kind == 1) w ^= one << b1;
            if (kind == 2) w ^= (one << b1) ^ (one << b2);
            if (kind == 3) w = {8'($urandom), $urandom, $urandom};
            tick($urandom_range(0, 9) < 8, w, $urandom_range(0, 99) < 3);
        end
        idle(4);

`ifdef SECDED_DEC_ERRLOG_EN
        tick(1'b0, 72'h0, 1'b1);
        tick(1'b1, one << 64, 1'b0);
        tick(1'b1, 72'h3, 1'b0);
        idle(4);
        chk("log_syn_ce", 72'(lsyn16), 72'h01);
        chk("log_vld_set", 72'(lvld16), 72'h1);
        tick(1'b0, 72'h0, 1'b1);
        idle(1);
        chk("log_vld_clr", 72'(lvld16), 72'h0);
`endif

        // reset with erroneous words in flight
        tick(1'b1, one << 5, 1'b0);
        tick(1'b1, 72'h3, 1'b0);
        tick(1'b1, one << 70, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 72'(bus16.out_valid), 72'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 72'(bus16.out_valid), 72'h0);
        chk("async_rst_ce",    72'(ce16), 72'h0);
        chk("async_rst_ue",    72'(ue16), 72'h0);
        bus16.in_valid = 0; bus4.in_valid = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secded_dec72.md
# secded_dec72

Pipelined 72→64 SECDED decoder: the read-side counterpart of `enc_top`, placed between cache data/tag array read ports and the consumer. It recomputes the check bits, forms the 8-bit syndrome, corrects any single-bit error, flags double (uncorrectable) errors, and keeps saturating error counters for scrubbing and reporting logic. It uses the same parity-check matrix as `enc_top`, so any `enc_top` codeword decodes cleanly.

## Interface
- `CNT_W`, 16: width of each error counter.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` holds a codeword this cycle.
- `in_data`  in  72: bits [63:0] are data, bits [71:64] are check bits.
- `cnt_clr`  in  1: synchronous clear of both counters.
- `out_valid`  out  1: the output fields are valid.
- `out_data`  out  64: corrected data.
- `out_syn`  out  8: syndrome of this word.
- `out_ce`  out  1: a single error was corrected.
- `out_ue`  out  1: the error is uncorrectable.
- `ce_cnt`  out  `CNT_W`: count of corrected errors, saturating.
- `ue_cnt`  out  `CNT_W`: count of uncorrectable errors, saturating.
- `log_syn`  out  8: syndrome of the first error (only with `SECDED_DEC_ERRLOG_EN`).
- `log_vld`  out  1: `log_syn` is valid (only with `SECDED_DEC_ERRLOG_EN`).

## Operation
- Column j of H (j = 0..63) is the 8-bit check vector that `enc_top` produces for IN = 1<<j. Check bit k (k = 0..7) has column 1<<k.
- Syndrome: `syn = H·in_data[63:0] XOR in_data[71:64]`.
- Classification, applied in this priority order:
  - syn == 0: clean. `out_data` = received data, `out_ce` = 0, `out_ue` = 0.
  - syn equals data column j: flip data bit j, `out_ce` = 1.
  - syn has exactly one bit set: check-bit error. Data passes unchanged, `out_ce` = 1.
  - Any other syndrome: `out_ue` = 1, raw data passes uncorrected, `out_ce` = 0.
- `out_ce` and `out_ue` are never both 1.
- Counters:
  - Increment by 1 when `out_valid` && `out_ce`, or when `out_valid` && `out_ue`, respectively.
  - Each counter holds at 2^CNT_W−1 (saturates, never wraps).
  - `cnt_clr` forces both counters to 0. It takes priority over a simultaneous increment, and that event is dropped.

## Timing
- Stage 1 registers `in_data` and the syndrome. Stage 2 registers the corrected data and the flags.
- Latency is exactly 2 cycles: `in_valid` at edge N gives `out_valid` at edge N+2.
- Throughput is one word per cycle. There is no backpressure.
- `out_data`, `out_syn`, `out_ce` and `out_ue` update only when the stage-2 valid is 1, and otherwise hold their last value.
- `out_ce` and `out_ue` are qualified by `out_valid`.
- Counters update one cycle after `out_valid`, i.e. they reflect word N at edge N+3.
- Reset (async assert, sync deassert assumed upstream):
  - All pipeline valids, `out_*`, counters, `log_syn` and `log_vld` go to 0.
  - Words in flight when reset asserts are discarded, with no output and no count.

## Configuration
- `SECDED_DEC_ERRLOG_EN` defined:
  - On the first `out_valid` with `out_ce` or `out_ue` while `log_vld` = 0, capture `out_syn` into `log_syn` and set `log_vld`.
  - The log then holds until `cnt_clr`, which clears both `log_syn` and `log_vld`.
  - If `cnt_clr` and a new error occur in the same cycle, clear wins.
- `SECDED_DEC_ERRLOG_EN` undefined: the `log_syn`/`log_vld` ports and logic are absent.

## Test plan
- Clean word: `in_data` = 72'h0, then a nonzero `enc_top` codeword for 64'hDEADBEEF_01234567. Required: `out_valid` 2 cycles later, data equal to the input data, `out_syn` = 0, `out_ce` = 0, `out_ue` = 0, counters unchanged.
- All 72 single flips of the zero codeword (`in_data` = 1<<i), back to back:
  - i < 64: `out_data` = 0, `out_ce` = 1, `out_syn` = column i.
  - i ≥ 64: `out_syn` = 1<<(i−64), `out_ce` = 1.
  - At the end, `ce_cnt` = 72 and `ue_cnt` = 0.
- Double flip: `in_data` = 72'h3 (bits 0 and 1). Required: `out_ue` = 1, `out_data` = 64'h3, `ue_cnt` +1, `ce_cnt` unchanged.
- Saturation with `CNT_W` = 4: 17 single-error words, then one more. Required: `ce_cnt` = 15 and holds. Then `cnt_clr` in the same cycle as a counted CE: required `ce_cnt` = 0.
- Reset mid-stream: assert `rst_n` low with two erroneous words in flight. Required: `out_valid` = 0 immediately (async), counters 0, no output for the in-flight words after release.
- `SECDED_DEC_ERRLOG_EN`: inject a CE on bit 64 (syn 8'h01), then a UE. Required: `log_syn` = 8'h01 and `log_vld` = 1, not overwritten by the UE; after `cnt_clr`, `log_vld` = 0.
